reg_wr_arbiter: RTL and testbench
=================================

# reg_wr_arbiter

Round-robin write-port arbiter for the integer register bank. Up to NUM_REQ writeback sources (ALU, load unit, CSR unit) compete for the single bank write port. Each cycle one source is granted, and one cycle later the block drives a registered one-hot set vector plus write data. That vector feeds the REG_Set inputs of the bank's REG_POS-style registers. Writes to x0 are accepted and discarded.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- REG_DATA_WIDTH, 32, write data width
- REG_ADDR_WIDTH, 5, register address width; bank holds 2**REG_ADDR_WIDTH registers
- REG_Clk  in  1  clock, rising edge
- REG_Reset  in  1  reset, asynchronous, active-low
- ARB_Hold  in  1  pipeline stall; while high, no grants are issued
- ARB_Req_Valid  in  NUM_REQ  per-requester write request
- ARB_Req_Addr  in  NUM_REQ*REG_ADDR_WIDTH  packed destination addresses; requester i occupies slice [i*W +: W]
- ARB_Req_Data  in  NUM_REQ*REG_DATA_WIDTH  packed write data, same packing
- ARB_Req_Ready  out  NUM_REQ  one-hot grant, combinational
- ARB_Set_OutBUS  out  2**REG_ADDR_WIDTH  registered one-hot register set strobes
- ARB_Data_OutBUS  out  REG_DATA_WIDTH  registered write data, common to all bank registers
- ARB_Grant_Id  out  3  registered index of the requester whose write is currently presented

## Operation
- A transfer occurs for requester i when ARB_Req_Valid[i] and ARB_Req_Ready[i] are both high at a rising edge.
- Requester obligations:
  - Once ARB_Req_Valid is raised, it stays high until accepted.
  - Address and data stay stable until accepted.
- Priority pointer `last` holds the index of the most recently granted requester.
  - Search order is last+1, last+2, ..., wrapping modulo NUM_REQ.
  - The first requester found with valid high is the winner.
- ARB_Req_Ready[winner] = 1 when ARB_Hold = 0. All other ready bits are 0.
- With ARB_Hold = 1 or no valid request, ARB_Req_Ready = 0.
- On a transfer:
  - `last` ← winner.
  - The output stage loads:
    - ARB_Set_OutBUS ← one-hot(addr), or all-zero if addr = 0 (x0).
    - ARB_Data_OutBUS ← data.
    - ARB_Grant_Id ← winner.
- Cycle with no transfer:
  - ARB_Set_OutBUS ← 0. Each strobe is exactly one cycle wide.
  - ARB_Data_OutBUS and ARB_Grant_Id hold their values.
  - `last` holds.
- The x0 write still counts as a transfer: requester is acknowledged and the pointer advances.
- Two requesters may target the same register in back-to-back grants. Both writes are issued in grant order, and the later one wins in the bank.
- ARB_Set_OutBUS has at most one bit set at any time.

## Timing
- Reset (asynchronous, REG_Reset low):
  - ARB_Set_OutBUS = 0, ARB_Data_OutBUS = 0, ARB_Grant_Id = 0.
  - `last` = NUM_REQ-1, so requester 0 has first priority after reset.
  - ARB_Req_Ready = 0 while reset is asserted.
- Reset asserted mid-operation: a pending strobe is cleared immediately and the write is lost. Requesters must re-present after reset.
- Latency: grant in cycle N, set strobe and data valid in cycle N+1, bank register updated at the end of N+1.
- Throughput: one write per cycle. Worst-case wait for any continuously valid requester is NUM_REQ-1 grants.
- ARB_Hold rising in cycle N: no grant in N. A strobe from a grant in N-1 is still issued in N.
- ARB_Req_Ready is combinational from ARB_Req_Valid, ARB_Hold and `last`. It has no combinational path from the address or data inputs.

## Structure
- Shared package holds:
  - default NUM_REQ, REG_DATA_WIDTH and REG_ADDR_WIDTH;
  - localparam X0_ADDR = 0;
  - requester index constants REQ_ALU = 0, REQ_LOAD = 1, REQ_CSR = 2.
- One sub-module, rr_priority_pick: combinational rotate, find-first, un-rotate.
  - Inputs: request vector, `last`.
  - Outputs: one-hot grant, encoded index, any-valid.
- The top level contains `last`, the address/data mux, the one-hot decoder and the output registers.

## Test plan
- Reset check: during and after reset, all outputs are 0. Raise valid on requesters 0 and 2 together → requester 0 granted first, requester 2 next cycle.
- All three valid continuously, addresses 5/6/7, data 0xA/0xB/0xC → grants 0,1,2,0,… Set strobes bits 5,6,7 in cycles N+1..N+3 with data 0xA, 0xB, 0xC.
- Requester 1 writes addr 0, data 0xFFFF → ready 1 for one cycle, ARB_Set_OutBUS stays 0, pointer advances to 1.
- ARB_Hold high for 3 cycles with requester 2 valid → ready stays 0. Grant comes in the first cycle after hold drops, strobe one cycle later.
- Requester 0 then requester 1, both writing addr 9 with 0x11 then 0x22 → strobes on bit 9 in consecutive cycles; the bank model ends at 0x22.
- REG_Reset pulsed low while a strobe for addr 3 is pending → ARB_Set_OutBUS goes 0 asynchronously and addr 3 is unchanged. After release, requester 0 has priority.

Source files
------------

// File: rtl/reg_wr_arbiter_pkg.sv
// Shared constants and helpers for the register-bank write-port arbiter.
package reg_wr_arbiter_pkg;

    localparam int DEF_NUM_REQ        = 3;
    localparam int DEF_REG_DATA_WIDTH = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int GRANT_ID_W         = 3;
    localparam int X0_ADDR            = 0;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_CSR  = 2;

    typedef logic [GRANT_ID_W-1:0] req_idx_t;

    // Operands never exceed 2*num_req-1, so one conditional subtract is a full modulo.
    function automatic int rr_wrap(input int idx, input int num_req);
        return (idx >= num_req) ? idx - num_req : idx;
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Writeback-source request bus and bank-side set/data bus of the write-port arbiter.
interface reg_wr_arbiter_if
    import reg_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
);
    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

    logic                                ARB_Hold;
    logic [NUM_REQ-1:0]                  ARB_Req_Valid;
    logic [NUM_REQ*REG_ADDR_WIDTH-1:0]   ARB_Req_Addr;
    logic [NUM_REQ*REG_DATA_WIDTH-1:0]   ARB_Req_Data;
    logic [NUM_REQ-1:0]                  ARB_Req_Ready;
    logic [NUM_REGS-1:0]                 ARB_Set_OutBUS;
    logic [REG_DATA_WIDTH-1:0]           ARB_Data_OutBUS;
    req_idx_t                            ARB_Grant_Id;

    modport master (
        output ARB_Hold, ARB_Req_Valid, ARB_Req_Addr, ARB_Req_Data,
        input  ARB_Req_Ready, ARB_Set_OutBUS, ARB_Data_OutBUS, ARB_Grant_Id
    );

    modport slave (
        input  ARB_Hold, ARB_Req_Valid, ARB_Req_Addr, ARB_Req_Data,
        output ARB_Req_Ready, ARB_Set_OutBUS, ARB_Data_OutBUS, ARB_Grant_Id
    );

endinterface

// File: rtl/reg_wr_arbiter_rr_priority_pick.sv
// Round-robin pick: rotate requests to start after `last`, find first, map back.
module rr_priority_pick
    import reg_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last,
    output logic [NUM_REQ-1:0] grant,
    output req_idx_t           grant_idx,
    output logic               any_valid
);

    logic [NUM_REQ-1:0] rot;
    int                 first_k;
    int                 win;

    always_comb begin
        rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == rr_wrap(int'(last) + 1 + k, NUM_REQ))
                    rot[k] = req[i];
            end
        end
    end

    // Scan from the far end so the lowest rotated position is the one left standing.
    always_comb begin
        any_valid = 1'b0;
        first_k   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any_valid = 1'b1;
                first_k   = k;
            end
        end
    end

    always_comb begin
        win       = rr_wrap(int'(last) + 1 + first_k, NUM_REQ);
        grant_idx = req_idx_t'(win);
        grant     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (any_valid && (i == win))
                grant[i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for the single register-bank write port; registered one-hot set strobes.
module reg_wr_arbiter
    import reg_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic            REG_Clk,
    input  logic            REG_Reset,
    reg_wr_arbiter_if.slave bus
);

    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

    req_idx_t                  last;
    logic [NUM_REQ-1:0]        pick_grant;
    req_idx_t                  pick_idx;
    logic                      pick_any;

    logic                      wr_vld_p0;
    logic [REG_ADDR_WIDTH-1:0] addr_p0;
    logic [REG_DATA_WIDTH-1:0] data_p0;

    logic [NUM_REGS-1:0]       set_p1;
    logic [REG_DATA_WIDTH-1:0] data_p1;
    req_idx_t                  id_p1;

    // x0 is hard-wired zero in the bank, so its write is acknowledged but produces no strobe.
    function automatic logic [NUM_REGS-1:0] set_decode(input logic [REG_ADDR_WIDTH-1:0] addr);
        if (addr == REG_ADDR_WIDTH'(X0_ADDR))
            return '0;
        return NUM_REGS'(1) << addr;
    endfunction

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req       (bus.ARB_Req_Valid),
        .last      (last),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    // Stage p0: grant decision and winner's address/data
    assign wr_vld_p0         = pick_any & ~bus.ARB_Hold & REG_Reset;
    assign bus.ARB_Req_Ready = wr_vld_p0 ? pick_grant : '0;

    always_comb begin
        addr_p0 = '0;
        data_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(pick_idx)) begin
                addr_p0 = bus.ARB_Req_Addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                data_p0 = bus.ARB_Req_Data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
            end
        end
    end

    // Stage p1: registered strobe, data and grant id presented to the bank
    always_ff @(posedge REG_Clk or negedge REG_Reset) begin
        if (!REG_Reset) begin
            last    <= req_idx_t'(NUM_REQ - 1);
            set_p1  <= '0;
            data_p1 <= '0;
            id_p1   <= '0;
        end else begin
            set_p1 <= '0;
            if (wr_vld_p0) begin
                last    <= pick_idx;
                set_p1  <= set_decode(addr_p0);
                data_p1 <= data_p0;
                id_p1   <= pick_idx;
            end
        end
    end

    assign bus.ARB_Set_OutBUS  = set_p1;
    assign bus.ARB_Data_OutBUS = data_p1;
    assign bus.ARB_Grant_Id    = id_p1;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed, table-driven bench for reg_wr_arbiter with a small register-bank model.
module tb_reg_wr_arbiter;
    import reg_wr_arbiter_pkg::*;

    localparam int NR    = 3;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    logic REG_Clk   = 1'b0;
    logic REG_Reset = 1'b0;
    logic bank_en   = 1'b0;

    reg_wr_arbiter_if #(.NUM_REQ(NR), .REG_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus();

    reg_wr_arbiter #(.NUM_REQ(NR), .REG_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .REG_Clk   (REG_Clk),
        .REG_Reset (REG_Reset),
        .bus       (bus.slave)
    );

    always #5 REG_Clk = ~REG_Clk;

    logic [DW-1:0] bank [NREGS];

    always @(posedge REG_Clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!bank_en)
                bank[i] <= '0;
            else if (bus.ARB_Set_OutBUS[i])
                bank[i] <= bus.ARB_Data_OutBUS;
        end
    end

    typedef struct {
        logic             hold;
        logic [NR-1:0]    valid;
        logic [NR*AW-1:0] addr;
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    exp_ready;
        logic [NREGS-1:0] exp_set;
        logic [DW-1:0]    exp_data;
        logic [2:0]       exp_id;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mkv(input logic hold, input logic [2:0] valid,
                                 input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [2:0] er, input int eset,
                                 input logic [31:0] ed, input logic [2:0] eid);
        vec_t v;
        v.hold      = hold;
        v.valid     = valid;
        v.addr      = {a2, a1, a0};
        v.data      = {d2, d1, d0};
        v.exp_ready = er;
        v.exp_set   = (eset < 0) ? '0 : (NREGS'(1) << eset);
        v.exp_data  = ed;
        v.exp_id    = eid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic hold, input logic [2:0] valid,
                         input logic [NR*AW-1:0] addr, input logic [NR*DW-1:0] data);
        bus.ARB_Hold      = hold;
        bus.ARB_Req_Valid = valid;
        bus.ARB_Req_Addr  = addr;
        bus.ARB_Req_Data  = data;
    endtask

    initial begin
        // Each row is one cycle: inputs driven early, outputs checked at the falling edge.
        // Expected set/data/id reflect the transfer of the previous row.
        vecs.push_back(mkv(0, 3'b101, 1, 0, 2, 32'h1, 0, 32'h2,     3'b001, -1, 32'h0, 0));
        vecs.push_back(mkv(0, 3'b100, 1, 0, 2, 32'h1, 0, 32'h2,     3'b100,  1, 32'h1, 0));
        vecs.push_back(mkv(0, 3'b000, 0, 0, 0, 0, 0, 0,             3'b000,  2, 32'h2, 2));
        vecs.push_back(mkv(0, 3'b111, 5, 6, 7, 32'hA, 32'hB, 32'hC, 3'b001, -1, 32'h2, 2));
        vecs.push_back(mkv(0, 3'b111, 5, 6, 7, 32'hA, 32'hB, 32'hC, 3'b010,  5, 32'hA, 0));
        vecs.push_back(mkv(0, 3'b111, 5, 6, 7, 32'hA, 32'hB, 32'hC, 3'b100,  6, 32'hB, 1));
        vecs.push_back(mkv(0, 3'b111, 5, 6, 7, 32'hA, 32'hB, 32'hC, 3'b001,  7, 32'hC, 2));
        vecs.push_back(mkv(0, 3'b000, 0, 0, 0, 0, 0, 0,             3'b000,  5, 32'hA, 0));
        vecs.push_back(mkv(0, 3'b010, 0, 0, 0, 0, 32'hFFFF, 0,      3'b010, -1, 32'hA, 0));
        vecs.push_back(mkv(0, 3'b000, 0, 0, 0, 0, 0, 0,             3'b000, -1, 32'hFFFF, 1));
        vecs.push_back(mkv(0, 3'b111, 5, 6, 7, 32'hA, 32'hB, 32'hC, 3'b100, -1, 32'hFFFF, 1));
        vecs.push_back(mkv(0, 3'b000, 0, 0, 0, 0, 0, 0,             3'b000,  7, 32'hC, 2));
        vecs.push_back(mkv(1, 3'b100, 0, 0, 4, 0, 0, 32'h44,        3'b000, -1, 32'hC, 2));
        vecs.push_back(mkv(1, 3'b100, 0, 0, 4, 0, 0, 32'h44,        3'b000, -1, 32'hC, 2));
        vecs.push_back(mkv(1, 3'b100, 0, 0, 4, 0, 0, 32'h44,        3'b000, -1, 32'hC, 2));
        vecs.push_back(mkv(0, 3'b100, 0, 0, 4, 0, 0, 32'h44,        3'b100, -1, 32'hC, 2));
        vecs.push_back(mkv(0, 3'b000, 0, 0, 0, 0, 0, 0,             3'b000,  4, 32'h44, 2));
        vecs.push_back(mkv(0, 3'b011, 9, 9, 0, 32'h11, 32'h22, 0,   3'b001, -1, 32'h44, 2));
        vecs.push_back(mkv(0, 3'b010, 9, 9, 0, 32'h11, 32'h22, 0,   3'b010,  9, 32'h11, 0));
        vecs.push_back(mkv(1, 3'b000, 0, 0, 0, 0, 0, 0,             3'b000,  9, 32'h22, 1));
        vecs.push_back(mkv(0, 3'b000, 0, 0, 0, 0, 0, 0,             3'b000, -1, 32'h22, 1));

        // Reset held with requests present: nothing may be granted or strobed.
        drive(0, 3'b101, {5'd2, 5'd0, 5'd1}, {32'h2, 32'h0, 32'h1});
        repeat (2) begin
            @(negedge REG_Clk);
            check("rst_ready", 32'(bus.ARB_Req_Ready), 32'h0);
            check("rst_set",   bus.ARB_Set_OutBUS, 32'h0);
            check("rst_data",  bus.ARB_Data_OutBUS, 32'h0);
            check("rst_id",    32'(bus.ARB_Grant_Id), 32'h0);
        end
        drive(0, 3'b000, '0, '0);
        REG_Reset = 1'b1;
        @(posedge REG_Clk);
        #1;
        bank_en = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r].hold, vecs[r].valid, vecs[r].addr, vecs[r].data);
            @(negedge REG_Clk);
            check($sformatf("v%0d_ready", r), 32'(bus.ARB_Req_Ready), 32'(vecs[r].exp_ready));
            check($sformatf("v%0d_set", r),   bus.ARB_Set_OutBUS, vecs[r].exp_set);
            check($sformatf("v%0d_data", r),  bus.ARB_Data_OutBUS, vecs[r].exp_data);
            check($sformatf("v%0d_id", r),    32'(bus.ARB_Grant_Id), 32'(vecs[r].exp_id));
            @(posedge REG_Clk);
            #1;
        end

        check("bank_x0",    bank[0], 32'h0);
        check("bank_r1",    bank[1], 32'h1);
        check("bank_r2",    bank[2], 32'h2);
        check("bank_r4",    bank[4], 32'h44);
        check("bank_r5",    bank[5], 32'hA);
        check("bank_r7",    bank[7], 32'hC);
        check("bank_r9",    bank[9], 32'h22);

        // Reset pulse while the addr-3 strobe is on the bus; last is 1 so requester 0 wins.
        drive(0, 3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h33});
        @(negedge REG_Clk);
        check("prst_ready", 32'(bus.ARB_Req_Ready), 32'h1);
        @(posedge REG_Clk);
        #1;
        check("prst_set", bus.ARB_Set_OutBUS, 32'h8);
        drive(0, 3'b111, {5'd7, 5'd6, 5'd5}, {32'hC, 32'hB, 32'hA});
        #1;
        REG_Reset = 1'b0;
        #1;
        check("arst_set",   bus.ARB_Set_OutBUS, 32'h0);
        check("arst_data",  bus.ARB_Data_OutBUS, 32'h0);
        check("arst_id",    32'(bus.ARB_Grant_Id), 32'h0);
        check("arst_ready", 32'(bus.ARB_Req_Ready), 32'h0);
        @(posedge REG_Clk);
        #1;
        check("arst_bank_r3", bank[3], 32'h0);
        @(negedge REG_Clk);
        REG_Reset = 1'b1;
        #1;
        check("post_rst_ready0", 32'(bus.ARB_Req_Ready), 32'h1);
        @(posedge REG_Clk);
        #1;
        check("post_rst_ready1", 32'(bus.ARB_Req_Ready), 32'h2);
        @(negedge REG_Clk);
        check("post_rst_set",  bus.ARB_Set_OutBUS, 32'h20);
        check("post_rst_data", bus.ARB_Data_OutBUS, 32'hA);
        check("post_rst_id",   32'(bus.ARB_Grant_Id), 32'(REQ_ALU));
        drive(0, 3'b000, '0, '0);
        @(posedge REG_Clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
